sbox_word_engine: RTL and testbench
===================================

SBOX_WORD_ENGINE -- requirements
Module: sbox_word_engine

Interface
REQ-001 The block SHALL have parameter NBYTES, default 4, meaning the number of bytes per word; legal values are 1..16.
REQ-002 The block SHALL have parameter LANES, default 1, meaning the number of parallel S-box lookups per cycle; LANES SHALL divide NBYTES.
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  an input word is offered.
REQ-007 in_ready  output  1  the block can accept a word.
REQ-008 in_encrypt  input  1  1 = forward AES S-box, 0 = inverse S-box; sampled only with the word.
REQ-009 in_data  input  8*NBYTES  input word; byte k is bits [8k+7:8k].
REQ-010 out_valid  output  1  out_data holds a completed word.
REQ-011 out_ready  input  1  downstream accepts the word.
REQ-012 out_data  output  8*NBYTES  substituted word; byte k is the substitution of input byte k.
REQ-013 out_encrypt  output  1  mode used for the word on out_data.
REQ-014 busy  output  1  high in RUN or HOLD.

Function
REQ-015 Tables SHALL be the FIPS-197 AES forward S-box and inverse S-box, 256 x 8 each.
REQ-016 FSM states: IDLE, RUN, HOLD; in_ready SHALL be 1 only in IDLE.
REQ-017 IDLE -> RUN on in_valid & in_ready; the word and in_encrypt SHALL be captured on that edge.
REQ-018 In RUN, each cycle SHALL substitute LANES consecutive bytes, lowest index first, using a batch index counter 0..NBYTES/LANES-1.
REQ-019 RUN -> HOLD on the edge that processes the last batch; the index SHALL wrap to 0 on that edge.
REQ-020 Latency: out_valid SHALL rise exactly NBYTES/LANES cycles after the accepting edge (4 cycles at defaults).
REQ-021 In HOLD, out_valid SHALL be 1, and out_data/out_encrypt SHALL be stable until out_valid & out_ready.
REQ-022 HOLD -> IDLE on out_valid & out_ready; no new word is accepted on that same edge; in_ready SHALL be 1 the following cycle.
REQ-023 Changes to in_data, in_encrypt or in_valid while in RUN/HOLD SHALL have no effect.
REQ-024 Throughput: one word per NBYTES/LANES + 2 cycles at most, with out_ready held high.
REQ-025 out_data SHALL read 0 outside HOLD; bytes not yet processed SHALL never be visible.

Reset
REQ-026 On rst: state IDLE; index 0; out_valid 0; out_data 0; out_encrypt 0; busy 0; in_ready SHALL be 1 the cycle after rst deasserts.
REQ-027 rst in RUN or HOLD SHALL discard the word in flight with no output handshake; rst SHALL take priority over every handshake on the same edge.

Configuration
REQ-028 Macro SBOX_WORD_COUNT_EN: when defined, the block SHALL add output word_count (16 bits), which increments on each out handshake, wraps FFFF->0000 and is cleared by rst.
REQ-029 Without SBOX_WORD_COUNT_EN, the word_count port and its logic SHALL be absent, with all other behaviour identical.

Verification
REQ-030 Defaults: encrypt=1, in_data=32'h000153FF -> out_data=32'h637CED16, with out_valid rising 4 cycles after acceptance.
REQ-031 Defaults: encrypt=0, in_data=32'h637CED16 -> out_data=32'h000153FF, and out_encrypt=0.
REQ-032 Hold out_ready=0 for 5 cycles -> out_valid and out_data are stable and in_ready stays 0; a new in_valid word is ignored.
REQ-033 Assert rst in the 2nd RUN cycle -> next cycle IDLE, out_valid=0, in_ready=1; the following word (encrypt, 32'h00000000) -> 32'h63636363.
REQ-034 NBYTES=16, LANES=4, encrypt: bytes 00..0F -> out_valid after 4 cycles, bytes 63 7C 77 7B F2 6B 6F C5 30 01 67 2B FE D7 AB 76.
REQ-035 With SBOX_WORD_COUNT_EN, 3 completed words -> word_count=3; forcing 65536 words -> 0.

Source files
------------

// File: rtl/sbox_word_engine.sv
// rtl/sbox_word_engine.sv - AES forward/inverse S-box word engine, LANES bytes per cycle
// Optional macro SBOX_WORD_COUNT_EN adds a 16-bit completed-word counter output.
module sbox_word_engine #(
    parameter int NBYTES = 4,
    parameter int LANES  = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_encrypt,
    input  logic [8*NBYTES-1:0] in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [8*NBYTES-1:0] out_data,
    output logic                out_encrypt,
    output logic                busy
`ifdef SBOX_WORD_COUNT_EN
    ,
    output logic [15:0]         word_count
`endif
);
    localparam int NBATCH = NBYTES / LANES;
    localparam int IDX_W  = (NBATCH > 1) ? $clog2(NBATCH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    // Entry 0 occupies the most significant byte of each table.
    localparam logic [2047:0] SBOX_FWD = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };
    localparam logic [2047:0] SBOX_INV = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] sbox(input logic enc, input logic [7:0] b);
        logic [10:0] pos;
        pos = 11'd2047 - {b, 3'b000};
        return enc ? SBOX_FWD[pos -: 8] : SBOX_INV[pos -: 8];
    endfunction

    logic [1:0]          state;
    logic [IDX_W-1:0]    idx;
    logic [8*NBYTES-1:0] word_r;
    logic                enc_r;
    logic                last_batch;
    logic [7:0]          lane_in  [LANES];
    logic [7:0]          lane_out [LANES];

    assign last_batch = (idx == IDX_W'(NBATCH - 1));

    // Only LANES lookups exist; the current batch is muxed onto them.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_in[l] = 8'h00;
            for (int b = 0; b < NBATCH; b++) begin
                if (idx == IDX_W'(b)) begin
                    lane_in[l] = word_r[8*(b*LANES+l) +: 8];
                end
            end
            lane_out[l] = sbox(enc_r, lane_in[l]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            idx    <= '0;
            word_r <= '0;
            enc_r  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        word_r <= in_data;
                        enc_r  <= in_encrypt;
                        idx    <= '0;
                        state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    for (int k = 0; k < NBYTES; k++) begin
                        if (idx == IDX_W'(k / LANES)) begin
                            word_r[8*k +: 8] <= lane_out[k % LANES];
                        end
                    end
                    if (last_batch) begin
                        idx   <= '0;
                        state <= S_HOLD;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Substitution is done in place, so the word is masked until complete.
    assign in_ready    = (state == S_IDLE);
    assign out_valid   = (state == S_HOLD);
    assign busy        = (state == S_RUN) || (state == S_HOLD);
    assign out_data    = out_valid ? word_r : '0;
    assign out_encrypt = out_valid & enc_r;

`ifdef SBOX_WORD_COUNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            word_count <= 16'h0000;
        end else if (out_valid && out_ready) begin
            word_count <= word_count + 16'h0001;
        end
    end
`endif

endmodule

// File: tb/tb_sbox_word_engine.sv
// tb/tb_sbox_word_engine.sv - self-checking bench for sbox_word_engine (4/1 and 16/4 builds)
module tb_sbox_word_engine;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         a_in_valid, a_in_encrypt, a_out_ready;
    logic [31:0]  a_in_data;
    logic         a_in_ready, a_out_valid, a_out_encrypt, a_busy;
    logic [31:0]  a_out_data;
    logic         b_in_valid, b_in_encrypt, b_out_ready;
    logic [127:0] b_in_data;
    logic         b_in_ready, b_out_valid, b_out_encrypt, b_busy;
    logic [127:0] b_out_data;
`ifdef SBOX_WORD_COUNT_EN
    logic [15:0]  a_word_count, b_word_count;
`endif

    sbox_word_engine #(.NBYTES(4), .LANES(1)) dut_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_encrypt(a_in_encrypt), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .out_encrypt(a_out_encrypt), .busy(a_busy)
`ifdef SBOX_WORD_COUNT_EN
        , .word_count(a_word_count)
`endif
    );

    sbox_word_engine #(.NBYTES(16), .LANES(4)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_encrypt(b_in_encrypt), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_encrypt(b_out_encrypt), .busy(b_busy)
`ifdef SBOX_WORD_COUNT_EN
        , .word_count(b_word_count)
`endif
    );

    int n_assert = 0;
    int n_fail   = 0;
    int wc_model = 0;
    logic [7:0] fwd_t [256];
    logic [7:0] inv_t [256];

    function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p, a, b;
        p = 8'h00; a = x; b = y;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    // Forward S-box: multiplicative inverse in GF(2^8) then the affine map.
    function automatic logic [7:0] aes_sbox(input logic [7:0] x);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 0; i < 254; i++) r = gmul(r, x);
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] ref_word(input logic enc, input logic [127:0] d, input int nb);
        logic [127:0] r;
        r = '0;
        for (int k = 0; k < nb; k++) r[8*k +: 8] = enc ? fwd_t[d[8*k +: 8]] : inv_t[d[8*k +: 8]];
        return r;
    endfunction

    function automatic logic rdy(input bit s); return s ? b_in_ready : a_in_ready; endfunction
    function automatic logic ov(input bit s); return s ? b_out_valid : a_out_valid; endfunction
    function automatic logic oe(input bit s); return s ? b_out_encrypt : a_out_encrypt; endfunction
    function automatic logic bz(input bit s); return s ? b_busy : a_busy; endfunction
    function automatic logic [127:0] od(input bit s);
        return s ? b_out_data : {96'h0, a_out_data};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit s, input logic v, input logic enc, input logic [127:0] d);
        if (s) begin
            b_in_valid = v; b_in_encrypt = enc; b_in_data = d;
        end else begin
            a_in_valid = v; a_in_encrypt = enc; a_in_data = d[31:0];
        end
    endtask

    task automatic set_ready(input bit s, input logic r);
        if (s) b_out_ready = r;
        else   a_out_ready = r;
    endtask

    task automatic xfer(input bit s, input logic enc, input logic [127:0] data,
                        input logic [127:0] exp, input int stall, input bit poke, input string tag);
        int n;
        logic [127:0] held;
        n = 0;
        while (!rdy(s) && n < 20) begin tick(); n++; end
        chk({tag, " in_ready"}, 128'(rdy(s)), 128'd1);
        drive(s, 1'b1, enc, data);
        tick();
        drive(s, 1'b0, ~enc, ~data);
        chk({tag, " busy_run"}, 128'(bz(s)), 128'd1);
        chk({tag, " ready_run"}, 128'(rdy(s)), 128'd0);
        chk({tag, " data_hidden"}, od(s), 128'd0);
        n = 0;
        while (!ov(s) && n < 20) begin tick(); n++; end
        chk({tag, " latency"}, 128'(n), 128'd4);
        chk({tag, " out_data"}, od(s), exp);
        chk({tag, " out_encrypt"}, 128'(oe(s)), 128'(enc));
        held = od(s);
        for (int i = 0; i < stall; i++) begin
            if (poke) drive(s, 1'b1, ~enc, {$urandom, $urandom, $urandom, $urandom});
            tick();
            chk({tag, " hold_valid"}, 128'(ov(s)), 128'd1);
            chk({tag, " hold_data"}, od(s), held);
            chk({tag, " hold_ready"}, 128'(rdy(s)), 128'd0);
        end
        drive(s, 1'b0, enc, data);
        set_ready(s, 1'b1);
        tick();
        set_ready(s, 1'b0);
        if (!s) wc_model++;
        chk({tag, " post_valid"}, 128'(ov(s)), 128'd0);
        chk({tag, " post_ready"}, 128'(rdy(s)), 128'd1);
    endtask

    initial begin
        int acc [$];
        int n;
        logic [127:0] d;
        logic e;

        for (int i = 0; i < 256; i++) begin
            fwd_t[i] = aes_sbox(8'(i));
            inv_t[fwd_t[i]] = 8'(i);
        end

        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, '0); drive(1'b1, 1'b0, 1'b0, '0);
        a_out_ready = 1'b0; b_out_ready = 1'b0;
        repeat (2) tick();
        chk("rst out_valid", 128'(a_out_valid), 128'd0);
        chk("rst out_data", 128'(a_out_data), 128'd0);
        chk("rst out_encrypt", 128'(a_out_encrypt), 128'd0);
        chk("rst busy", 128'(a_busy), 128'd0);
        chk("rst b busy", 128'(b_busy), 128'd0);
        rst = 1'b0;
        tick();
        chk("rst in_ready", 128'(a_in_ready), 128'd1);

        xfer(1'b0, 1'b1, 128'h000153FF, 128'h637CED16, 0, 1'b0, "enc_vec");
        xfer(1'b0, 1'b0, 128'h637CED16, 128'h000153FF, 0, 1'b0, "dec_vec");
        xfer(1'b0, 1'b1, 128'h3243F6A8, ref_word(1'b1, 128'h3243F6A8, 4), 5, 1'b1, "stall5");
        tick();
        chk("stall5 ignored_word", 128'(a_busy), 128'd0);

        // Reset during the second RUN cycle discards the word.
        drive(1'b0, 1'b1, 1'b1, 128'hDEADBEEF);
        tick();
        drive(1'b0, 1'b0, 1'b0, '0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst out_valid", 128'(a_out_valid), 128'd0);
        chk("mid_rst in_ready", 128'(a_in_ready), 128'd1);
        chk("mid_rst busy", 128'(a_busy), 128'd0);
        xfer(1'b0, 1'b1, 128'h00000000, 128'h63636363, 0, 1'b0, "after_rst");

        xfer(1'b1, 1'b1, 128'h0F0E0D0C0B0A09080706050403020100,
             128'h76ABD7FE2B670130C56F6BF27B777C63, 0, 1'b0, "wide_vec");

        for (int i = 0; i < 12; i++) begin
            d = {96'h0, $urandom};
            e = 1'($urandom_range(0, 1));
            xfer(1'b0, e, d, ref_word(e, d, 4), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), "rand_a");
        end
        for (int i = 0; i < 6; i++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            e = 1'($urandom_range(0, 1));
            xfer(1'b1, e, d, ref_word(e, d, 16), int'($urandom_range(0, 3)), 1'b0, "rand_b");
        end

        // Back-to-back words with out_ready held high.
        a_out_ready = 1'b1;
        drive(1'b0, 1'b1, 1'b1, 128'hA5C3_0F96);
        for (int i = 0; i < 30; i++) begin
            if (a_in_ready) acc.push_back(i);
            if (a_out_valid) begin
                wc_model++;
                chk("thru out_data", 128'(a_out_data), ref_word(1'b1, 128'hA5C30F96, 4));
            end
            tick();
        end
        drive(1'b0, 1'b0, 1'b0, '0);
        n = 0;
        while (!a_in_ready && n < 20) begin
            if (a_out_valid) wc_model++;
            tick();
            n++;
        end
        a_out_ready = 1'b0;
        chk("thru drained", 128'(a_in_ready), 128'd1);
        chk("thru accepts", 128'(acc.size()), 128'd5);
        for (int i = 1; i < acc.size(); i++) chk("thru period", 128'(acc[i] - acc[i-1]), 128'd6);

`ifdef SBOX_WORD_COUNT_EN
        chk("word_count", 128'(a_word_count), 128'(wc_model[15:0]));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("word_count rst", 128'(a_word_count), 128'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
